// File: rtl/rr_req_stage8_if.sv
// Lane-side and output-side flit handshakes of the 8-lane round-robin request stage.
// slave is the stage itself, master is whoever drives the lanes and consumes the output.
interface rr_req_stage8_if #(
    parameter int DATA_W = 64
);
    logic [7:0]          in_valid;
    logic [8*DATA_W-1:0] in_data;
    logic [7:0]          in_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [2:0]          out_src;
    logic                out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_req_stage8.sv
// Eight 2-deep lane FIFOs feeding an external round-robin arbiter; the granted head
// is moved into a registered output slot, and malformed grants are flagged and counted.
module rr_req_stage8 #(
    parameter int DATA_W = 64
) (
    input  logic           clk,
    input  logic           reset,
    rr_req_stage8_if.slave bus,
    output logic [7:0]     req,
    output logic           arb_en,
    input  logic [7:0]     gnt,
    output logic           gnt_err,
    output logic [7:0]     err_cnt
);

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    // Only meaningful for a one-hot input; OR-encoding avoids a priority chain.
    function automatic logic [2:0] onehot_idx8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (v[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

    logic [1:0]        count_q [8];
    logic [1:0]        count_d [8];
    logic [DATA_W-1:0] head_q  [8];
    logic [DATA_W-1:0] head_d  [8];
    logic [DATA_W-1:0] tail_q  [8];
    logic [DATA_W-1:0] tail_d  [8];

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [2:0]        out_src_q,   out_src_d;
    logic              gnt_err_q,   gnt_err_d;
    logic [7:0]        err_cnt_q,   err_cnt_d;

    logic [7:0] full_s;
    logic [7:0] push_s;
    logic [7:0] pop_s;
    logic       gnt_legal_s;
    logic       gnt_illegal_s;
    logic [2:0] gnt_idx_s;

    // Lane status, arbiter handshake and grant legality
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            req[i]    = (count_q[i] != 2'd0);
            full_s[i] = (count_q[i] == 2'd2);
        end
        bus.in_ready  = reset ? 8'h00 : ~full_s;
        arb_en        = reset | ~out_valid_q | bus.out_ready;
        gnt_legal_s   = arb_en && is_onehot8(gnt) && ((gnt & ~req) == 8'h00);
        gnt_illegal_s = (gnt != 8'h00) && !gnt_legal_s;
        gnt_idx_s     = onehot_idx8(gnt);
        // Fullness is judged before this cycle's pop, so a full lane never takes a push.
        push_s        = bus.in_valid & ~full_s;
        pop_s         = gnt_legal_s ? gnt : 8'h00;
    end

    // Per-lane two-entry FIFO update
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            count_d[i] = count_q[i];
            head_d[i]  = head_q[i];
            tail_d[i]  = tail_q[i];
            case ({push_s[i], pop_s[i]})
                2'b10: begin
                    if (count_q[i] == 2'd0) begin
                        head_d[i] = bus.in_data[i*DATA_W +: DATA_W];
                    end else begin
                        tail_d[i] = bus.in_data[i*DATA_W +: DATA_W];
                    end
                    count_d[i] = count_q[i] + 2'd1;
                end
                2'b01: begin
                    head_d[i]  = tail_q[i];
                    count_d[i] = count_q[i] - 2'd1;
                end
                // Push+pop only happens at count 1: the new flit replaces the head.
                2'b11: begin
                    head_d[i] = bus.in_data[i*DATA_W +: DATA_W];
                end
                default: begin
                end
            endcase
        end
    end

    // Output slot load/drain and illegal-grant bookkeeping
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (gnt_legal_s) begin
            out_valid_d = 1'b1;
            out_data_d  = head_q[gnt_idx_s];
            out_src_d   = gnt_idx_s;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        gnt_err_d = gnt_err_q | gnt_illegal_s;
        if (gnt_illegal_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                count_q[i] <= 2'd0;
                head_q[i]  <= {DATA_W{1'b0}};
                tail_q[i]  <= {DATA_W{1'b0}};
            end
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
            out_src_q   <= 3'd0;
            gnt_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                count_q[i] <= count_d[i];
                head_q[i]  <= head_d[i];
                tail_q[i]  <= tail_d[i];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            gnt_err_q   <= gnt_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign gnt_err       = gnt_err_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: doc/rr_req_stage8.md
RR_REQ_STAGE8 -- requirements
Module: rr_req_stage8

Interface
REQ-001 SHALL have parameter: DATA_W, 64, flit width in bits.
REQ-002 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  8  per-lane flit valid.
REQ-005 SHALL have port: in_data  input  8*DATA_W  lane i flit at bits [i*DATA_W +: DATA_W].
REQ-006 SHALL have port: in_ready  output  8  per-lane accept.
REQ-007 SHALL have port: req  output  8  request vector to the 8-way round-robin arbiter.
REQ-008 SHALL have port: arb_en  output  1  arbitration enable to the arbiter.
REQ-009 SHALL have port: gnt  input  8  grant from the arbiter, same-cycle combinational response to req/arb_en.
REQ-010 SHALL have port: out_valid  output  1  registered output flit valid.
REQ-011 SHALL have port: out_data  output  DATA_W  registered output flit.
REQ-012 SHALL have port: out_src  output  3  lane index of out_data.
REQ-013 SHALL have port: out_ready  input  1  downstream accept.
REQ-014 SHALL have port: gnt_err  output  1  sticky illegal-grant flag.
REQ-015 SHALL have port: err_cnt  output  8  saturating illegal-grant count.

Function
REQ-016 SHALL hold one 2-entry FIFO per lane, each with a count of 0..2.
REQ-017 SHALL drive in_ready[i] = (count_i != 2), from registered state only, with no dependency on same-cycle pop.
REQ-018 SHALL push lane i on in_valid[i] && in_ready[i].
REQ-019 SHALL drive req[i] = (count_i != 0); a flit pushed at edge E raises req in the cycle after E.
REQ-020 SHALL drive arb_en = !out_valid || out_ready.
REQ-021 SHALL treat a grant as legal iff arb_en=1, gnt is one-hot, and (gnt & ~req) == 0.
REQ-022 SHALL treat gnt=0 as no action and not as an error.
REQ-023 SHALL treat any nonzero gnt that is not legal as illegal: no pop, no output load.
REQ-024 SHALL, on a legal grant to lane k, pop lane k's head at the next edge and load out_data = head, out_src = k, out_valid = 1.
REQ-025 SHALL otherwise clear out_valid when out_ready = 1, and otherwise hold out_valid, out_data and out_src unchanged.
REQ-026 SHALL preserve FIFO order within a lane; same-edge push and pop at count 1 leaves count 1, with the new flit becoming head.
REQ-027 SHALL NOT accept a push on a full lane even when that lane pops in the same cycle.
REQ-028 SHALL give a minimum input-to-out_valid latency of 2 edges (push edge, then grant edge).
REQ-029 SHALL sustain 1 flit/cycle at the output while out_ready = 1 and any lane is nonempty.
REQ-030 SHALL set gnt_err on any illegal grant and keep it set until reset.
REQ-031 SHALL increment err_cnt by 1 per illegal-grant cycle, saturating at 255.

Reset
REQ-032 SHALL, while reset = 1, drive in_ready = 8'h00 and arb_en = 1, and clear all lane counts (req = 0).
REQ-033 SHALL, after the reset edge, have out_valid = 0, out_data = 0, out_src = 0, gnt_err = 0, err_cnt = 0, and in_ready = 8'hFF once reset deasserts.
REQ-034 SHALL, on reset asserted mid-operation, discard buffered and output flits without emitting them.

Verification
REQ-035 SHALL cover: push 0xA1 on lane 3, gnt mirrors req -> req = 8'h08 the next cycle; out_valid = 1, out_src = 3, out_data = 0xA1 one edge later.
REQ-036 SHALL cover: lane 5 pushed 3 times with no grant -> in_ready[5] = 0 after 2 pushes; third flit not accepted; count = 2.
REQ-037 SHALL cover: out_valid = 1, out_ready = 0 for 4 cycles -> arb_en = 0, out_data stable, no pops; out_ready = 1 resumes 1 flit/cycle.
REQ-038 SHALL cover: illegal grants gnt = 8'h03, then gnt = 8'h40 with req[6] = 0 -> no pop, gnt_err = 1, err_cnt = 2; 300 illegal cycles -> err_cnt = 255.
REQ-039 SHALL cover: lanes 0 and 7 each hold 2 flits, reference round-robin arbiter with out_ready = 1 -> output order src 0, 7, 0, 7 with per-lane data order preserved.
REQ-040 SHALL cover: reset asserted while 3 lanes are nonempty and out_valid = 1 -> after the reset edge req = 0, out_valid = 0, and in_ready = 8'hFF once reset deasserts.
